w_update_seq: RTL

Chunked weight-update sequencer for the Axiline training datapath; the broadcast counterpart of the inner-product reduction. It takes the scalar gradient term produced downstream of the inner product and applies w_new = w − ((g·x) >>> lr_shift) across a feature vector. The vector is streamed as `chunks` slices of `size` lanes each, with valid/ready handshakes on input and output. It sits between the x/w buffers and the weight write-back path.

---
 rtl/axiline_pkg.sv | 19 +
 rtl/w_update_lane.sv | 28 ++
 rtl/w_update_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/axiline_pkg.sv
// Shared types and sizing helpers for the Axiline training datapath blocks.
package axiline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_BITWIDTH = 8;
    localparam int DEFAULT_SIZE     = 8;
    localparam int DEFAULT_CHUNKS   = 4;

    // Shift amounts up to 2*bitwidth-1 cover the whole full-width product.
    function automatic int shiftWidth(input int bw);
        return $clog2(2 * bw);
    endfunction

endpackage

// File: rtl/w_update_lane.sv
// One lane of the weight update: w_out = w - ((g * x) >>> lr_shift), wrapping.
module w_update_lane
    import axiline_pkg::*;
#(
    parameter int bitwidth = DEFAULT_BITWIDTH,
    parameter int SW       = shiftWidth(DEFAULT_BITWIDTH)
) (
    input  logic [bitwidth-1:0] g,
    input  logic [SW-1:0]       lr_shift,
    input  logic [bitwidth-1:0] x_i,
    input  logic [bitwidth-1:0] w_i,
    output logic [bitwidth-1:0] w_out_i
);

    logic signed [2*bitwidth-1:0] gExt;
    logic signed [2*bitwidth-1:0] xExt;
    logic signed [2*bitwidth-1:0] prod;
    logic signed [2*bitwidth-1:0] quot;

    // Sign-extend first so the product keeps its full 2*bitwidth precision.
    assign gExt = {{bitwidth{g[bitwidth-1]}}, g};
    assign xExt = {{bitwidth{x_i[bitwidth-1]}}, x_i};
    assign prod = gExt * xExt;
    assign quot = prod >>> lr_shift;

    assign w_out_i = w_i - bitwidth'(quot);

endmodule

// File: rtl/w_update_seq.sv
// Chunked weight-update sequencer: streams x/w slices through per-lane update
// logic into a single-stage output register under valid/ready flow control.
module w_update_seq
    import axiline_pkg::*;
#(
    parameter  int bitwidth = DEFAULT_BITWIDTH,
    parameter  int size     = DEFAULT_SIZE,
    parameter  int chunks   = DEFAULT_CHUNKS,
    localparam int SW       = shiftWidth(bitwidth)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [bitwidth-1:0]      g,
    input  logic [SW-1:0]            lr_shift,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [bitwidth*size-1:0] x,
    input  logic [bitwidth*size-1:0] w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bitwidth*size-1:0] w_out,
    output logic                     out_last,
    output logic                     done
);

    // Counter reaches `chunks` after the final slice, so it never wraps mid-vector.
    localparam int             CW       = $clog2(chunks + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(chunks - 1);

    state_t                   state_q,    state_d;
    logic [bitwidth-1:0]      gLat_q,     gLat_d;
    logic [SW-1:0]            shiftLat_q, shiftLat_d;
    logic [CW-1:0]            cnt_q,      cnt_d;
    logic [bitwidth*size-1:0] wOut_q,     wOut_d;
    logic                     outValid_q, outValid_d;
    logic                     outLast_q,  outLast_d;
    logic                     done_q,     done_d;

    logic [bitwidth*size-1:0] laneOut;
    logic                     inReady;
    logic                     accept;
    logic                     outHs;

    for (genvar i = 0; i < size; i++) begin : gLane
        w_update_lane #(
            .bitwidth (bitwidth),
            .SW       (SW)
        ) uLane (
            .g        (gLat_q),
            .lr_shift (shiftLat_q),
            .x_i      (x[bitwidth*i +: bitwidth]),
            .w_i      (w[bitwidth*i +: bitwidth]),
            .w_out_i  (laneOut[bitwidth*i +: bitwidth])
        );
    end

    // A slice may enter only when the output register is empty or draining this cycle.
    assign inReady = (state_q == RUN) && (!outValid_q || out_ready);
    assign accept  = in_valid && inReady;
    assign outHs   = outValid_q && out_ready;

    always_comb begin
        state_d    = state_q;
        gLat_d     = gLat_q;
        shiftLat_d = shiftLat_q;
        cnt_d      = cnt_q;
        wOut_d     = wOut_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    gLat_d     = g;
                    shiftLat_d = lr_shift;
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (accept && (cnt_q == LAST_IDX)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outHs && outLast_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh acceptance refills the register in the same cycle it drains.
        if (accept) begin
            wOut_d     = laneOut;
            outValid_d = 1'b1;
            outLast_d  = (cnt_q == LAST_IDX);
            cnt_d      = cnt_q + 1'b1;
        end else if (outHs) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gLat_q     <= '0;
            shiftLat_q <= '0;
            cnt_q      <= '0;
            wOut_q     <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gLat_q     <= gLat_d;
            shiftLat_q <= shiftLat_d;
            cnt_q      <= cnt_d;
            wOut_q     <= wOut_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign in_ready  = inReady;
    assign out_valid = outValid_q;
    assign w_out     = wOut_q;
    assign out_last  = outLast_q;
    assign done      = done_q;

endmodule
